pattern_score_judge: RTL and testbench
======================================

Name: pattern_score_judge

Overview:
- Parametrised successor to the pattern-detect display stage. Sits after the chromakey, sobel and polygon-mask stages, in front of the VGA output mux.
- Produces the per-pixel overlay colour with 1-cycle registered latency.
- In judge mode, accumulates per-frame in-pattern and out-of-pattern body pixel counts. At frame end, an iterative divider computes a 0..100 score, which is classified into perfect/good/bad and held until the next judgment.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- PERFECT_TH, 80, score >= PERFECT_TH gives perfect.
- GOOD_TH, 50, GOOD_TH <= score < PERFECT_TH gives good.
- SCORE_MODE, 0. 0 = hit ratio 100*g/(g+r). 1 = net ratio 100*max(g-r,0)/(g+r).
- CNT_W, $clog2(H_ACT*V_ACT+1), width of the pixel counters.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- pixel_en  in  1  active-video pixel qualifier
- frame_start  in  1  1-cycle pulse, first cycle of a frame
- frame_end  in  1  1-cycle pulse, last active pixel of a frame
- game_in  in  1  1 = play/preview mode, 0 = judge mode
- in_polygon  in  1  pixel lies inside the target pattern
- chroma  in  1  1 = background (chromakey cloth), 0 = person
- sobel  in  1  edge pixel
- in_r  in  5  camera red
- in_g  in  6  camera green
- in_b  in  5  camera blue
- red  out  8  overlay red
- grn  out  8  overlay green
- blu  out  8  overlay blue
- score  out  7  last computed score, 0..100
- score_valid  out  1  1-cycle pulse when score/perfect/good/bad update
- perfect  out  1  held classification
- good  out  1  held classification
- bad  out  1  held classification
- busy  out  1  divider running
- overrun  out  1  1-cycle pulse when frame_end arrives while busy

Behaviour:
- Reset: every output is 0, including red/grn/blu, score, all flags and counters; FSM goes to IDLE. perfect/good/bad stay all-zero until the first score_valid; after that exactly one is high.
- Reset asserted mid-division aborts the division: no score_valid, previous result lost.
- Colour path: registered, 1-cycle latency, independent of pixel_en.
  - game_in=1:
    - poly & person: camera RGB expanded by MSB replication (r={in_r,in_r[4:2]}, g={in_g,in_g[5:4]}, b={in_b,in_b[4:2]}).
    - poly & bg: 00FF00.
    - !poly & person & edge: FF0000.
    - !poly & person & !edge: FF8888.
    - !poly & bg: 87CEFA.
  - game_in=0:
    - poly & person & edge: 00FF00.
    - poly & person & !edge: 88FF88.
    - poly & bg: FFFFFF.
    - !poly & person: FF0000 (edge) or FF8888 (non-edge).
    - !poly & bg: FFFF00.
- Counters g_cnt, r_cnt (CNT_W bits, saturating at all-ones).
  - A cycle counts when pixel_en & !game_in & !chroma: in_polygon increments g_cnt, otherwise r_cnt.
  - frame_start clears both. If frame_start coincides with a counted pixel, the result is count = 1.
- FSM IDLE -> LOAD -> DIV -> DONE -> IDLE.
  - IDLE: frame_end latches the counts, including any pixel counted in the same cycle, then goes to LOAD. Counters are not cleared by frame_end.
  - LOAD, one cycle:
    - D = g+r, CNT_W+1 bits.
    - N = 100*g (mode 0) or 100*(g>r ? g-r : 0) (mode 1), CNT_W+7 bits.
    - If D = 0, go directly to DONE with quotient 0.
  - DIV: restoring division, one quotient bit per cycle, CNT_W+7 cycles, quotient truncated.
  - DONE, one cycle:
    - score = quotient[6:0], which is always <= 100.
    - Flags: perfect = score >= PERFECT_TH; good = score >= GOOD_TH and not perfect; bad otherwise.
    - score_valid pulses; return to IDLE.
- Latency: frame_end at cycle T gives score_valid at T+CNT_W+9. When D = 0, score_valid is at T+2.
- busy is high in LOAD, DIV and DONE.
- frame_end while busy: not queued. overrun pulses that cycle and the in-flight result completes unaffected.
- game_in may change at any time; it only gates counting and colour selection.

Test Plan:
- Judge mode, frame with g=90, r=10, SCORE_MODE=0 -> score_valid at T+CNT_W+9 with score=90, perfect=1, good=0, bad=0.
- g=60, r=40: SCORE_MODE=0 -> score=60, good=1. SCORE_MODE=1 -> score=20, bad=1. g=30, r=70 in SCORE_MODE=1 -> score=0, bad=1.
- Threshold edges: g=80, r=20 -> 80, perfect. g=79, r=21 -> 79, good. g=50, r=50 (mode 0) -> 50, good. g=49, r=51 -> 49, bad.
- Empty frame (all chroma=1, or game_in=1 throughout) -> score=0, bad=1, score_valid at T+2.
- Second frame_end during DIV -> overrun=1 for one cycle; the first result still arrives with the correct value and only one score_valid is produced. Reset pulse mid-DIV -> all outputs 0, no score_valid.
- Colour sweep: every game_in/in_polygon/chroma/sobel combination -> expected 24-bit colour one cycle later. in_r=5'h1F, in_g=6'h3F, in_b=0 in play mode inside polygon on a person -> FFFF00.

Source files
------------

// File: rtl/pattern_score_judge_if.sv
// Bundle of the per-pixel stage inputs and the judge/overlay outputs of
// pattern_score_judge.
//   master : upstream pipeline side (drives pixel qualifiers and flags)
//   slave  : pattern_score_judge side (drives overlay colour and score)
interface pattern_score_judge_if;
  logic       pixel_en;
  logic       frame_start;
  logic       frame_end;
  logic       game_in;
  logic       in_polygon;
  logic       chroma;
  logic       sobel;
  logic [4:0] in_r;
  logic [5:0] in_g;
  logic [4:0] in_b;
  logic [7:0] red;
  logic [7:0] grn;
  logic [7:0] blu;
  logic [6:0] score;
  logic       score_valid;
  logic       perfect;
  logic       good;
  logic       bad;
  logic       busy;
  logic       overrun;

  modport master (
    output pixel_en, frame_start, frame_end, game_in, in_polygon, chroma, sobel,
           in_r, in_g, in_b,
    input  red, grn, blu, score, score_valid, perfect, good, bad, busy, overrun
  );

  modport slave (
    input  pixel_en, frame_start, frame_end, game_in, in_polygon, chroma, sobel,
           in_r, in_g, in_b,
    output red, grn, blu, score, score_valid, perfect, good, bad, busy, overrun
  );
endinterface

// File: rtl/pattern_score_judge.sv
// Pattern score judge: overlay colour generation plus per-frame scoring.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : pattern_score_judge_if.slave
//     in : pixel_en, frame_start, frame_end, game_in, in_polygon, chroma,
//          sobel, in_r/in_g/in_b (RGB565 camera pixel)
//     out: red/grn/blu (registered overlay, 1-cycle latency), score (0..100),
//          score_valid pulse, held perfect/good/bad, busy, overrun pulse
// Body pixels (chroma=0) seen in judge mode are counted inside (g) and
// outside (r) the pattern; at frame_end a restoring divider produces
// 100*g/(g+r) (or the net ratio) one quotient bit per cycle.
module pattern_score_judge #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int PERFECT_TH = 80,
  parameter int GOOD_TH    = 50,
  parameter int SCORE_MODE = 0,
  parameter int CNT_W      = $clog2(H_ACT*V_ACT+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pattern_score_judge_if.slave  bus
);
  localparam int NW = CNT_W + 7;        // dividend / quotient width
  localparam int DW = CNT_W + 1;        // divisor width
  localparam int RW = DW + 1;           // shifted partial remainder width
  localparam int IW = $clog2(NW + 1);   // step counter width
  localparam logic [6:0] PERF7 = 7'(PERFECT_TH);
  localparam logic [6:0] GOOD7 = 7'(GOOD_TH);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t state, state_nxt;

  // ---------------- colour path ----------------
  logic        person;
  logic [23:0] rgb_nxt, rgb_q;

  assign person = ~bus.chroma;

  always_comb begin
    rgb_nxt = 24'h000000;
    if (bus.game_in) begin
      if (bus.in_polygon)
        rgb_nxt = person ? {bus.in_r, bus.in_r[4:2], bus.in_g, bus.in_g[5:4],
                            bus.in_b, bus.in_b[4:2]} : 24'h00FF00;
      else if (person)
        rgb_nxt = bus.sobel ? 24'hFF0000 : 24'hFF8888;
      else
        rgb_nxt = 24'h87CEFA;
    end else begin
      if (bus.in_polygon)
        rgb_nxt = person ? (bus.sobel ? 24'h00FF00 : 24'h88FF88) : 24'hFFFFFF;
      else
        rgb_nxt = person ? (bus.sobel ? 24'hFF0000 : 24'hFF8888) : 24'hFFFF00;
    end
  end

  // ---------------- pixel counters ----------------
  logic             count_en;
  logic [CNT_W-1:0] g_cnt, r_cnt, g_nxt, r_nxt;

  assign count_en = bus.pixel_en & ~bus.game_in & ~bus.chroma;

  // frame_start clears first, so a pixel counted in the same cycle lands as 1.
  always_comb begin
    g_nxt = g_cnt;
    r_nxt = r_cnt;
    if (bus.frame_start) begin
      g_nxt = '0;
      r_nxt = '0;
    end
    if (count_en) begin
      if (bus.in_polygon) g_nxt = (&g_nxt) ? g_nxt : g_nxt + CNT_W'(1);
      else                r_nxt = (&r_nxt) ? r_nxt : r_nxt + CNT_W'(1);
    end
  end

  // ---------------- divider ----------------
  logic [CNT_W-1:0] g_lat, r_lat, diff, base;
  logic [DW-1:0]    den, d_load, rem, rem_nxt;
  logic [NW-1:0]    num, num_nxt, n_load;
  logic [RW-1:0]    rem_sh, den_ext;
  logic [IW-1:0]    step;
  logic             q_bit, res_load;
  logic [6:0]       res;

  assign d_load  = {1'b0, g_lat} + {1'b0, r_lat};
  assign diff    = (g_lat > r_lat) ? g_lat - r_lat : '0;
  assign base    = (SCORE_MODE != 0) ? diff : g_lat;
  assign n_load  = NW'(base) * NW'(100);

  // num doubles as the quotient: dividend bits shift out of the top while
  // quotient bits shift in at the bottom.
  assign rem_sh  = {rem, num[NW-1]};
  assign den_ext = {1'b0, den};
  assign q_bit   = (rem_sh >= den_ext);
  assign rem_nxt = q_bit ? DW'(rem_sh - den_ext) : DW'(rem_sh);
  assign num_nxt = {num[NW-2:0], q_bit};

  // Result is captured on the edge entering DONE so it is visible in DONE.
  assign res_load = ((state == LOAD) && (d_load == '0)) ||
                    ((state == DIV)  && (step == '0));
  assign res      = (state == LOAD) ? 7'd0 : num_nxt[6:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.frame_end) state_nxt = LOAD;
      LOAD: state_nxt = (d_load == '0) ? DONE : DIV;
      DIV:  if (step == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  logic [6:0] score_q;
  logic       perfect_q, good_q, bad_q, is_perf, is_good;

  assign is_perf = (res >= PERF7);
  assign is_good = (res >= GOOD7) && !is_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q     <= '0;
      g_cnt     <= '0;
      r_cnt     <= '0;
      g_lat     <= '0;
      r_lat     <= '0;
      den       <= '0;
      num       <= '0;
      rem       <= '0;
      step      <= '0;
      score_q   <= '0;
      perfect_q <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      rgb_q <= rgb_nxt;
      g_cnt <= g_nxt;
      r_cnt <= r_nxt;
      case (state)
        IDLE: if (bus.frame_end) begin
          g_lat <= g_nxt;
          r_lat <= r_nxt;
        end
        LOAD: begin
          den  <= d_load;
          num  <= n_load;
          rem  <= '0;
          step <= IW'(NW - 1);
        end
        DIV: begin
          num  <= num_nxt;
          rem  <= rem_nxt;
          step <= step - IW'(1);
        end
        default: ;
      endcase
      if (res_load) begin
        score_q   <= res;
        perfect_q <= is_perf;
        good_q    <= is_good;
        bad_q     <= !is_perf && !is_good;
      end
    end
  end

  assign bus.red         = rgb_q[23:16];
  assign bus.grn         = rgb_q[15:8];
  assign bus.blu         = rgb_q[7:0];
  assign bus.score       = score_q;
  assign bus.perfect     = perfect_q;
  assign bus.good        = good_q;
  assign bus.bad         = bad_q;
  assign bus.busy        = (state != IDLE);
  assign bus.score_valid = (state == DONE);
  assign bus.overrun     = bus.frame_end & (state != IDLE);
endmodule

// File: tb/tb_pattern_score_judge.sv
module tb_pattern_score_judge;
  localparam int LAT = 28;   // CNT_W(19) + 9 for 640x480

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       pixel_en = 0, frame_start = 0, frame_end = 0, game_in = 0;
  logic       in_polygon = 0, chroma = 0, sobel = 0;
  logic [4:0] in_r = 0, in_b = 0;
  logic [5:0] in_g = 0;

  pattern_score_judge_if if0 ();
  pattern_score_judge_if if1 ();

  assign if0.pixel_en = pixel_en;   assign if1.pixel_en = pixel_en;
  assign if0.frame_start = frame_start; assign if1.frame_start = frame_start;
  assign if0.frame_end = frame_end; assign if1.frame_end = frame_end;
  assign if0.game_in = game_in;     assign if1.game_in = game_in;
  assign if0.in_polygon = in_polygon; assign if1.in_polygon = in_polygon;
  assign if0.chroma = chroma;       assign if1.chroma = chroma;
  assign if0.sobel = sobel;         assign if1.sobel = sobel;
  assign if0.in_r = in_r;           assign if1.in_r = in_r;
  assign if0.in_g = in_g;           assign if1.in_g = in_g;
  assign if0.in_b = in_b;           assign if1.in_b = in_b;

  pattern_score_judge #(.SCORE_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  pattern_score_judge #(.SCORE_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [23:0] colour(input logic gm, poly, chr, sob,
                                         input logic [4:0] r, input logic [5:0] g,
                                         input logic [4:0] b);
    logic [23:0] c;
    if (gm && poly && !chr)       c = {r, r[4:2], g, g[5:4], b, b[4:2]};
    else if (gm && poly)          c = 24'h00FF00;
    else if (gm && chr)           c = 24'h87CEFA;
    else if (!gm && poly && chr)  c = 24'hFFFFFF;
    else if (!gm && poly)         c = sob ? 24'h00FF00 : 24'h88FF88;
    else if (!gm && chr)          c = 24'hFFFF00;
    else                          c = sob ? 24'hFF0000 : 24'hFF8888;
    return c;
  endfunction

  function automatic int exp_score(input int mode, input int g, input int r);
    if (g + r == 0) return 0;
    if (mode == 0) return (100 * g) / (g + r);
    return (g > r) ? (100 * (g - r)) / (g + r) : 0;
  endfunction

  function automatic logic [2:0] exp_flags(input int s);
    if (s >= 80) return 3'b100;
    if (s >= 50) return 3'b010;
    return 3'b001;
  endfunction

  logic [23:0] m_rgb = 0;
  int          cyc = 0, mg = 0, mr = 0, done_edge = -1;
  bit          m_busy = 0, m_sv = 0;
  int          pend_s [2];
  int          held_s [2] = '{0, 0};
  logic [2:0]  held_f [2] = '{3'b000, 3'b000};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rgb = 0; mg = 0; mr = 0; done_edge = -1; m_busy = 0; m_sv = 0;
      for (int i = 0; i < 2; i++) begin held_s[i] = 0; held_f[i] = 3'b000; end
    end else begin
      cyc++;
      m_rgb = colour(game_in, in_polygon, chroma, sobel, in_r, in_g, in_b);
      if (frame_start) begin mg = 0; mr = 0; end
      if (pixel_en && !game_in && !chroma) begin
        if (in_polygon) mg++; else mr++;
      end
      if (frame_end && !m_busy) begin
        done_edge = cyc + ((mg + mr == 0) ? 2 : LAT) - 1;
        for (int i = 0; i < 2; i++) pend_s[i] = exp_score(i, mg, mr);
      end
      m_busy = (cyc <= done_edge);
      m_sv   = (cyc == done_edge);
      if (m_sv)
        for (int i = 0; i < 2; i++) begin
          held_s[i] = pend_s[i];
          held_f[i] = exp_flags(pend_s[i]);
        end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rgb0", {if0.red, if0.grn, if0.blu}, m_rgb);
      chk("rgb1", {if1.red, if1.grn, if1.blu}, m_rgb);
      chk("score0", if0.score, held_s[0]);
      chk("score1", if1.score, held_s[1]);
      chk("flags0", {if0.perfect, if0.good, if0.bad}, held_f[0]);
      chk("flags1", {if1.perfect, if1.good, if1.bad}, held_f[1]);
      chk("sv0", if0.score_valid, m_sv);
      chk("sv1", if1.score_valid, m_sv);
      chk("busy0", if0.busy, m_busy);
      chk("busy1", if1.busy, m_busy);
      chk("overrun0", if0.overrun, frame_end && m_busy);
      chk("overrun1", if1.overrun, frame_end && m_busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pixel_en = 0; frame_start = 0; frame_end = 0; chroma = 0;
    in_polygon = 0; sobel = 0;
  endtask

  // Pixel order: g in-pattern bodies, then background, then r out-of-pattern
  // bodies; frame_start rides the first pixel, frame_end the last.
  task automatic drive_frame(input int ng, input int nr, input int nbg, input bit gm);
    int total;
    total = ng + nr + nbg;
    for (int k = 0; k < total; k++) begin
      pixel_en    = 1;
      game_in     = gm;
      in_polygon  = (k < ng);
      chroma      = (k >= ng) && (k < ng + nbg);
      sobel       = k[0];
      in_r        = 5'(k); in_g = 6'(k * 3); in_b = 5'(k * 7);
      frame_start = (k == 0);
      frame_end   = (k == total - 1);
      tick();
    end
    idle();
    game_in = 0;
  endtask

  task automatic wait_sv(output int n);
    n = 1;
    forever begin
      @(negedge clk);
      if (if0.score_valid) return;
      if (n >= 100) begin
        chk("sv_timeout", if0.score_valid, 1);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic judge(input string nm, input int s0, input int s1,
                       input logic [2:0] f0, input logic [2:0] f1, input int lat);
    int n;
    wait_sv(n);
    if (lat > 0) chk({nm, "_lat"}, n, lat);
    chk({nm, "_s0"}, if0.score, s0);
    chk({nm, "_s1"}, if1.score, s1);
    chk({nm, "_f0"}, {if0.perfect, if0.good, if0.bad}, f0);
    chk({nm, "_f1"}, {if1.perfect, if1.good, if1.bad}, f1);
    tick();
    repeat (2) tick();
  endtask

  initial begin
    idle();
    tick();
    cmp_en = 1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_rgb", {if0.red, if0.grn, if0.blu}, 0);
    chk("rst_flags", {if0.perfect, if0.good, if0.bad, if0.score}, 0);
    rst_n = 1;
    repeat (2) tick();

    // Colour sweep over all mode/polygon/chroma/edge combinations.
    in_r = 5'h15; in_g = 6'h2A; in_b = 5'h0C;
    for (int c = 0; c < 16; c++) begin
      game_in = c[3]; in_polygon = c[2]; chroma = c[1]; sobel = c[0];
      tick();
    end
    game_in = 1; in_polygon = 1; chroma = 0; sobel = 0;
    in_r = 5'h1F; in_g = 6'h3F; in_b = 5'h00;
    tick();
    @(negedge clk);
    chk("col_yellow", {if0.red, if0.grn, if0.blu}, 24'hFFFF00);
    game_in = 0; in_polygon = 0; chroma = 0; sobel = 0;
    tick();
    @(negedge clk);
    chk("col_pink", {if0.red, if0.grn, if0.blu}, 24'hFF8888);
    idle(); game_in = 0;
    tick();

    drive_frame(90, 10, 3, 0); judge("f90", 90, 80, 3'b100, 3'b100, LAT);
    drive_frame(60, 40, 2, 0); judge("f60", 60, 20, 3'b010, 3'b001, LAT);
    drive_frame(30, 70, 1, 0); judge("f30", 30, 0,  3'b001, 3'b001, LAT);
    drive_frame(80, 20, 1, 0); judge("f80", 80, 60, 3'b100, 3'b010, LAT);
    drive_frame(79, 21, 1, 0); judge("f79", 79, 58, 3'b010, 3'b010, LAT);
    drive_frame(50, 50, 1, 0); judge("f50", 50, 0,  3'b010, 3'b001, LAT);
    drive_frame(49, 51, 1, 0); judge("f49", 49, 0,  3'b001, 3'b001, LAT);
    drive_frame(0, 0, 5, 0);   judge("empty", 0, 0, 3'b001, 3'b001, 2);
    drive_frame(90, 10, 2, 0); judge("f90b", 90, 80, 3'b100, 3'b100, LAT);
    drive_frame(20, 5, 2, 1);  judge("play", 0, 0, 3'b001, 3'b001, 2);

    // Second frame_end mid-division: flagged, not queued.
    drive_frame(60, 40, 1, 0);
    repeat (5) tick();
    frame_end = 1;
    @(negedge clk);
    chk("overrun_lit", if0.overrun, 1);
    tick();
    frame_end = 0;
    judge("ovr", 60, 20, 3'b010, 3'b001, -1);
    repeat (40) tick();

    // Reset mid-division: result aborted and held outputs cleared.
    drive_frame(90, 10, 1, 0);
    repeat (6) tick();
    rst_n = 0;
    @(negedge clk);
    chk("midrst_busy", if0.busy, 0);
    chk("midrst_flags", {if0.perfect, if0.good, if0.bad, if0.score}, 0);
    repeat (3) tick();
    rst_n = 1;
    repeat (40) tick();
    @(negedge clk);
    chk("postrst_flags", {if1.perfect, if1.good, if1.bad, if1.score}, 0);
    tick();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
